// File: rtl/ex_stage.sv
// Execute stage: 8-bit ALU with a multi-cycle shift-add multiplier.
// Every output is registered; MUL stalls upstream for eight cycles.
module ex_stage (
  input  logic       clk,
  input  logic       reset,
  input  logic       valid_in,
  input  logic [7:0] op_a_in,
  input  logic [7:0] op_b_in,
  input  logic [7:0] imm_in,
  input  logic       imm_sel_in,
  input  logic [3:0] alu_op_in,
  input  logic       mem_rw_in,
  input  logic       mem_en_in,
  input  logic       mem_mux_sel_in,
  output logic [7:0] ans_ex,
  output logic [7:0] DM_data,
  output logic       mem_rw_ex,
  output logic       mem_en_ex,
  output logic       mem_mux_sel_dm,
  output logic [3:0] flag_ex,
  output logic       valid_ex,
  output logic       stall_ex
);

  localparam logic [0:0] S_IDLE     = 1'b0;
  localparam logic [0:0] S_MUL_BUSY = 1'b1;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_XOR  = 4'h4;
  localparam logic [3:0] OP_NOT  = 4'h5;
  localparam logic [3:0] OP_SLL  = 4'h6;
  localparam logic [3:0] OP_SRL  = 4'h7;
  localparam logic [3:0] OP_SRA  = 4'h8;
  localparam logic [3:0] OP_MUL  = 4'h9;
  localparam logic [3:0] OP_SLT  = 4'hA;
  localparam logic [3:0] OP_PASS = 4'hB;

  logic [0:0]  r_state;
  logic [2:0]  r_cnt;
  logic [15:0] r_mcand;
  logic [7:0]  r_mplier;
  logic [15:0] r_prod;
  logic [7:0]  r_dm_data;
  logic        r_rw;
  logic        r_en;
  logic        r_mux;

  logic [7:0]  w_b;
  logic [8:0]  w_sum9;
  logic [8:0]  w_diff9;
  logic [7:0]  w_res;
  logic        w_c;
  logic        w_v;
  logic [15:0] w_prod_next;

  // Single-cycle ALU; MUL is handled by the iterative datapath below.
  always_comb begin
    w_b     = imm_sel_in ? imm_in : op_b_in;
    w_sum9  = {1'b0, op_a_in} + {1'b0, w_b};
    w_diff9 = {1'b0, op_a_in} - {1'b0, w_b};
    w_res   = 8'h00;
    w_c     = 1'b0;
    w_v     = 1'b0;
    case (alu_op_in)
      OP_ADD: begin
        w_res = w_sum9[7:0];
        w_c   = w_sum9[8];
        w_v   = (op_a_in[7] == w_b[7]) && (w_sum9[7] != op_a_in[7]);
      end
      OP_SUB: begin
        w_res = w_diff9[7:0];
        w_c   = w_diff9[8];
        w_v   = (op_a_in[7] != w_b[7]) && (w_diff9[7] != op_a_in[7]);
      end
      OP_AND:  w_res = op_a_in & w_b;
      OP_OR:   w_res = op_a_in | w_b;
      OP_XOR:  w_res = op_a_in ^ w_b;
      OP_NOT:  w_res = ~op_a_in;
      OP_SLL:  w_res = op_a_in << w_b[2:0];
      OP_SRL:  w_res = op_a_in >> w_b[2:0];
      OP_SRA:  w_res = $unsigned($signed(op_a_in) >>> w_b[2:0]);
      OP_SLT:  w_res = ($signed(op_a_in) < $signed(w_b)) ? 8'h01 : 8'h00;
      OP_PASS: w_res = w_b;
      default: w_res = 8'h00;
    endcase
  end

  // One shift-add step: accumulate the multiplicand when the multiplier LSB is set.
  always_comb begin
    w_prod_next = r_prod + (r_mplier[0] ? r_mcand : 16'h0000);
  end

  // Control FSM and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;   r_cnt <= 3'd0;
      r_mcand <= 16'h0000; r_mplier <= 8'h00; r_prod <= 16'h0000;
      r_dm_data <= 8'h00;  r_rw <= 1'b0; r_en <= 1'b0; r_mux <= 1'b0;
      ans_ex <= 8'h00; DM_data <= 8'h00; flag_ex <= 4'h0;
      mem_rw_ex <= 1'b0; mem_en_ex <= 1'b0; mem_mux_sel_dm <= 1'b0;
      valid_ex <= 1'b0; stall_ex <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (valid_in && (alu_op_in == OP_MUL)) begin
            r_mcand <= {8'h00, op_a_in}; r_mplier <= w_b; r_prod <= 16'h0000;
            r_dm_data <= op_b_in; r_rw <= mem_rw_in; r_en <= mem_en_in; r_mux <= mem_mux_sel_in;
            r_cnt <= 3'd0; r_state <= S_MUL_BUSY; stall_ex <= 1'b1;
            ans_ex <= 8'h00; DM_data <= 8'h00; flag_ex <= 4'h0;
            mem_rw_ex <= 1'b0; mem_en_ex <= 1'b0; mem_mux_sel_dm <= 1'b0; valid_ex <= 1'b0;
          end else if (valid_in) begin
            ans_ex  <= w_res;
            DM_data <= op_b_in;
            flag_ex <= {(w_res == 8'h00), w_res[7], w_c, w_v};
            mem_rw_ex <= mem_rw_in; mem_en_ex <= mem_en_in; mem_mux_sel_dm <= mem_mux_sel_in;
            valid_ex <= 1'b1; stall_ex <= 1'b0;
          end else begin
            ans_ex <= 8'h00; DM_data <= 8'h00; flag_ex <= 4'h0;
            mem_rw_ex <= 1'b0; mem_en_ex <= 1'b0; mem_mux_sel_dm <= 1'b0;
            valid_ex <= 1'b0; stall_ex <= 1'b0;
          end
        end
        S_MUL_BUSY: begin
          r_prod   <= w_prod_next;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + 3'd1;
          // The eighth step completes the product; publish it directly from the adder.
          if (r_cnt == 3'd7) begin
            ans_ex  <= w_prod_next[7:0];
            DM_data <= r_dm_data;
            flag_ex <= {(w_prod_next[7:0] == 8'h00), w_prod_next[7], (w_prod_next[15:8] != 8'h00), 1'b0};
            mem_rw_ex <= r_rw; mem_en_ex <= r_en; mem_mux_sel_dm <= r_mux;
            valid_ex <= 1'b1; stall_ex <= 1'b0; r_state <= S_IDLE;
          end else begin
            stall_ex <= 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE; stall_ex <= 1'b0; valid_ex <= 1'b0; mem_en_ex <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: stimulus pushes expected results, a
// negedge monitor pops and compares whenever valid_ex is presented.
module tb_ex_stage;

  logic       clk = 1'b0;
  logic       reset;
  logic       valid_in;
  logic [7:0] op_a_in, op_b_in, imm_in;
  logic       imm_sel_in;
  logic [3:0] alu_op_in;
  logic       mem_rw_in, mem_en_in, mem_mux_sel_in;
  logic [7:0] ans_ex, DM_data;
  logic       mem_rw_ex, mem_en_ex, mem_mux_sel_dm;
  logic [3:0] flag_ex;
  logic       valid_ex, stall_ex;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [7:0] ans;
    logic [3:0] flags;
    logic [7:0] dm;
    logic       en;
    logic       rw;
    logic       mux;
  } exp_t;

  exp_t exp_q[$];

  ex_stage dut (
    .clk(clk), .reset(reset), .valid_in(valid_in),
    .op_a_in(op_a_in), .op_b_in(op_b_in), .imm_in(imm_in), .imm_sel_in(imm_sel_in),
    .alu_op_in(alu_op_in), .mem_rw_in(mem_rw_in), .mem_en_in(mem_en_in),
    .mem_mux_sel_in(mem_mux_sel_in), .ans_ex(ans_ex), .DM_data(DM_data),
    .mem_rw_ex(mem_rw_ex), .mem_en_ex(mem_en_ex), .mem_mux_sel_dm(mem_mux_sel_dm),
    .flag_ex(flag_ex), .valid_ex(valid_ex), .stall_ex(stall_ex)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] imm, input logic isel, input logic en, input logic rw,
                       input logic mux);
    valid_in = v; alu_op_in = op; op_a_in = a; op_b_in = b; imm_in = imm;
    imm_sel_in = isel; mem_en_in = en; mem_rw_in = rw; mem_mux_sel_in = mux;
  endtask

  task automatic expect_out(input logic [7:0] ans, input logic [3:0] flags, input logic [7:0] dm,
                            input logic en, input logic rw, input logic mux);
    exp_t e;
    e.ans = ans; e.flags = flags; e.dm = dm; e.en = en; e.rw = rw; e.mux = mux;
    exp_q.push_back(e);
  endtask

  task automatic idle();
    drive(1'b0, 4'h0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Present one single-cycle op for one edge, then return to a bubble.
  task automatic single(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] imm, input logic isel, input logic en, input logic rw,
                        input logic mux, input logic [7:0] ans, input logic [3:0] flags);
    drive(1'b1, op, a, b, imm, isel, en, rw, mux);
    expect_out(ans, flags, b, en, rw, mux);
    @(posedge clk); #1;
    idle();
  endtask

  // MUL accepted at edge k; optionally hold an ADD 01+02 during the stall.
  task automatic do_mul(input logic [7:0] a, input logic [7:0] b, input logic en, input logic rw,
                        input logic mux, input logic [7:0] ans, input logic [3:0] flags,
                        input logic hold_add);
    drive(1'b1, 4'h9, a, b, 8'h00, 1'b0, en, rw, mux);
    expect_out(ans, flags, b, en, rw, mux);
    @(posedge clk); #1;
    if (hold_add) begin
      drive(1'b1, 4'h0, 8'h01, 8'h02, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
      expect_out(8'h03, 4'b0000, 8'h02, 1'b0, 1'b0, 1'b0);
    end else begin
      idle();
    end
    check("mul_stall_k1", {31'd0, stall_ex}, 32'd1);
    check("mul_bubble_k1", {30'd0, valid_ex, mem_en_ex}, 32'd0);
    for (int i = 2; i <= 8; i++) begin
      @(posedge clk); #1;
      check("mul_stall", {31'd0, stall_ex}, 32'd1);
      check("mul_no_valid", {31'd0, valid_ex}, 32'd0);
    end
    @(posedge clk); #1;
    check("mul_done_stall", {31'd0, stall_ex}, 32'd0);
    check("mul_done_valid", {31'd0, valid_ex}, 32'd1);
    if (hold_add) begin
      @(posedge clk); #1;
      idle();
    end
  endtask

  // Scoreboard monitor: each presented result must match the oldest expectation.
  always @(negedge clk) begin
    if (!reset && valid_ex) begin
      if (exp_q.size() == 0) begin
        check("unexpected_valid", {24'd0, ans_ex}, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("result", {9'd0, ans_ex, flag_ex, DM_data, mem_en_ex, mem_rw_ex, mem_mux_sel_dm},
              {9'd0, e.ans, e.flags, e.dm, e.en, e.rw, e.mux});
      end
    end
  end

  initial begin
    reset = 1'b1;
    idle();
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", {8'd0, ans_ex, DM_data, flag_ex, mem_rw_ex, mem_en_ex, mem_mux_sel_dm,
          valid_ex, stall_ex}, 32'd0);
    reset = 1'b0;

    // Flags are {Z,N,C,V}.
    single(4'h0, 8'h7F, 8'h01, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h80, 4'b0101);
    @(posedge clk); #1;
    check("bubble_after_add", {22'd0, ans_ex, mem_en_ex, valid_ex}, 32'd0);
    single(4'h1, 8'h05, 8'h33, 8'h05, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 4'b1000);
    single(4'h1, 8'h03, 8'h04, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'hFF, 4'b0110);
    single(4'h0, 8'h80, 8'h80, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'b1011);
    single(4'h0, 8'h10, 8'hA5, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 8'h10, 4'b0000);
    single(4'h8, 8'h90, 8'h03, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'hF2, 4'b0100);
    single(4'hA, 8'hFF, 8'h01, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h01, 4'b0000);
    single(4'hE, 8'h12, 8'h34, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'b1000);
    single(4'h6, 8'h81, 8'h08, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h81, 4'b0100);
    single(4'h7, 8'hF0, 8'h04, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h0F, 4'b0000);
    single(4'h5, 8'h0F, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'hF0, 4'b0100);
    single(4'h2, 8'hCC, 8'hAA, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h88, 4'b0100);
    single(4'h4, 8'hCC, 8'hAA, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h66, 4'b0000);
    single(4'hB, 8'h00, 8'h11, 8'h7E, 1'b1, 1'b0, 1'b0, 1'b1, 8'h7E, 4'b0000);

    do_mul(8'h12, 8'h10, 1'b0, 1'b0, 1'b0, 8'h20, 4'b0010, 1'b1);
    do_mul(8'hFF, 8'hFF, 1'b1, 1'b0, 1'b1, 8'h01, 4'b0010, 1'b0);
    do_mul(8'h07, 8'h06, 1'b0, 1'b0, 1'b0, 8'h2A, 4'b0000, 1'b0);

    // Reset at edge k+4 of a MUL; its result must never surface.
    drive(1'b1, 4'h9, 8'h03, 8'h05, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1);
    @(posedge clk); #1;
    idle();
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check("abort_outputs", {8'd0, ans_ex, DM_data, flag_ex, mem_rw_ex, mem_en_ex, mem_mux_sel_dm,
          valid_ex, stall_ex}, 32'd0);
    reset = 1'b0;
    single(4'h0, 8'h20, 8'h22, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h42, 4'b0000);
    repeat (12) @(posedge clk);
    #1;
    check("stall_after_abort", {31'd0, stall_ex}, 32'd0);
    check("scoreboard_drained", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
